apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-outstanding APB master that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers.
- Sits directly upstream of the 16x32 APB register-file slave, driving its Paddr/Psel/Penable/Pwrite/Pwdata and consuming its Pready/Prdata.
- Returns one response per command: read data plus an error flag.
- Matches the slave's registered Prdata, which is valid the cycle after the completing ACCESS cycle.

Parameters:
- ADDR_W, 4, APB address width; the slave decodes 4 bits.
- DATA_W, 32, data width of Pwdata, Prdata, cmd_wdata and rsp_rdata.
- RDATA_DLY, 1, cycles between the ACCESS completion edge and Prdata being valid. 0 = combinational slave data, 1 = registered slave data (default).
- TIMEOUT, 16, maximum ACCESS cycles with Pready low before abort. Used only when APB_MASTER_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- Presetn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers.
- rsp_err  out  1  transfer aborted by timeout; tied 0 when the feature is compiled out.
- busy  out  1  high in any state other than IDLE.
- Paddr  out  ADDR_W  APB address.
- Psel  out  1  APB select.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Pwdata  out  DATA_W  APB write data.
- Pready  in  1  APB ready from slave.
- Prdata  in  DATA_W  APB read data from slave.

Behaviour:
- Reset (Presetn low, asynchronous): state goes to IDLE.
  - Psel, Penable, Pwrite, Paddr, Pwdata, rsp_valid, rsp_rdata and rsp_err all go to 0.
  - Timeout counter goes to 0.
  - A reset during SETUP, ACCESS or RCAP abandons the transfer and produces no response.
- States: IDLE, SETUP, ACCESS, RCAP.
  - cmd_ready = (state==IDLE), combinational. Exactly one transfer is outstanding.
- IDLE:
  - Psel=0, Penable=0.
  - On cmd_valid, latch Paddr<=cmd_addr and Pwrite<=cmd_write. Latch Pwdata<=cmd_wdata on writes only; on reads Pwdata holds its previous value.
  - Next state: SETUP.
- SETUP (exactly 1 cycle): Psel=1, Penable=0. Next state: ACCESS.
- ACCESS: Psel=1, Penable=1. Paddr, Pwrite and Pwdata are stable from SETUP through the end of ACCESS.
  - Pready low: stay in ACCESS (wait state).
  - Pready high, write: next IDLE; rsp_valid<=1, rsp_rdata<=0, rsp_err<=0.
  - Pready high, read, RDATA_DLY=0: next IDLE; rsp_rdata<=Prdata, rsp_valid<=1.
  - Pready high, read, RDATA_DLY=1: next RCAP.
- RCAP (read, RDATA_DLY=1 only; exactly 1 cycle): Psel=0, Penable=0. Capture rsp_rdata<=Prdata, set rsp_valid<=1, next IDLE.
- rsp_valid is high for exactly one cycle per completed or aborted command; there is no backpressure on the response. rsp_rdata and rsp_err hold their values until the next response.
- Latency from the accept edge to rsp_valid high:
  - write: 3 cycles with zero wait states.
  - read: 3 cycles (RDATA_DLY=0) or 4 cycles (RDATA_DLY=1).
  - Each wait state adds 1 cycle.
- Throughput: back-to-back writes issue every 3 cycles, because the next command is accepted in the IDLE cycle where rsp_valid is high.
- Paddr, Pwrite and Pwdata hold their last values when idle; they never glitch while Psel is high.
- A Pready pulse outside ACCESS is ignored.
- busy=1 in SETUP, ACCESS and RCAP.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with Pready low.
  - When the counter reaches TIMEOUT with Pready still low, the transfer aborts: Psel=0 and Penable=0 in the next cycle, state goes to IDLE, and the response is rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - If Pready is high in the same cycle the counter reaches TIMEOUT, the transfer completes normally with no error.
- Not defined: no counter; ACCESS waits indefinitely for Pready; rsp_err is constant 0.

Test Plan:
- Write path: write addr 4'h3, data 32'hDEADBEEF, with the slave attached. Then read addr 3. Required: rsp_valid 4 cycles after read accept, rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Back-to-back writes: 16 writes (addr i, data 32'h1000_0000+i) with cmd_valid held high. Required: cmd_ready pulses every 3 cycles, and every Psel-high window lasts exactly 2 cycles with Penable high in the 2nd only. Then 16 reads return the matching data in order.
- Wait states: model slave holds Pready low for 3 ACCESS cycles, read with RDATA_DLY=0 and Prdata=32'hA5A5A5A5. Required: Penable high 4 cycles, Paddr stable throughout, rsp_rdata=32'hA5A5A5A5.
- Timeout (macro on, TIMEOUT=4): Pready stuck low. Required: Psel drops after 4 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0. The next command is accepted and completes with rsp_err=0.
- Mid-transfer reset: assert Presetn low asynchronously (between clock edges) during ACCESS of a write. Required: Psel, Penable, rsp_valid=0 immediately, state IDLE, no response after reset release.
- Reset values and stability: after reset all outputs are 0 and cmd_ready=1. A stray Pready pulse while IDLE produces no rsp_valid.

Source files
------------

// File: rtl/apb_master_bridge.sv
//------------------------------------------------------------------------------
// apb_master_bridge
//
// Single-outstanding APB master. A command accepted on the valid/ready
// interface becomes one APB SETUP + ACCESS transfer. Each command produces
// exactly one response pulse carrying read data and an error flag.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   : ACCESS is aborted after TIMEOUT cycles with Pready low and the
//               response carries rsp_err=1, rsp_rdata=0.
//   undefined : ACCESS waits for Pready indefinitely; rsp_err is constant 0.
//
// Parameters
//   ADDR_W    : APB address width
//   DATA_W    : data width
//   RDATA_DLY : 0 = slave Prdata valid in the completing ACCESS cycle,
//               1 = slave Prdata valid one cycle later (registered slave)
//   TIMEOUT   : ACCESS wait-cycle limit (1..255), timeout build only
//
// Ports
//   PCLK, Presetn                       : clock, async active-low reset
//   cmd_valid/cmd_ready                 : command handshake
//   cmd_write, cmd_addr, cmd_wdata      : command fields
//   rsp_valid, rsp_rdata, rsp_err       : one-cycle response
//   busy                                : transfer in progress
//   Paddr, Psel, Penable, Pwrite, Pwdata: APB request outputs
//   Pready, Prdata                      : APB slave response inputs
//------------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32,
   parameter int RDATA_DLY = 1,
   parameter int TIMEOUT   = 16
) (
   input  logic              PCLK,
   input  logic              Presetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] Paddr,
   output logic              Psel,
   output logic              Penable,
   output logic              Pwrite,
   output logic [DATA_W-1:0] Pwdata,
   input  logic              Pready,
   input  logic [DATA_W-1:0] Prdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RCAP   = 2'd3
   } state_t;

   state_t state_reg;
   logic   tmo_hit;   // ACCESS wait budget exhausted (meaningful only while Pready low)

   generate
      if (TIMEOUT < 1 || TIMEOUT > 255 || RDATA_DLY < 0 || RDATA_DLY > 1) begin : g_bad_cfg
         $error("apb_master_bridge: TIMEOUT must be 1..255 and RDATA_DLY 0 or 1");
      end
   endgenerate

   assign cmd_ready = (state_reg == S_IDLE);
   assign busy      = (state_reg != S_IDLE);

   always_ff @(posedge PCLK or negedge Presetn) begin
      if (!Presetn) begin
         state_reg <= S_IDLE;
         Psel      <= 1'b0;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Paddr     <= '0;
         Pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  Paddr  <= cmd_addr;
                  Pwrite <= cmd_write;
                  // Reads leave Pwdata untouched so the bus does not toggle needlessly.
                  if (cmd_write) begin
                     Pwdata <= cmd_wdata;
                  end
                  Psel      <= 1'b1;
                  state_reg <= S_SETUP;
               end
            end
            S_SETUP: begin
               Penable   <= 1'b1;
               state_reg <= S_ACCESS;
            end
            S_ACCESS: begin
               if (Pready) begin
                  Psel    <= 1'b0;
                  Penable <= 1'b0;
                  if (Pwrite || RDATA_DLY == 0) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= Pwrite ? '0 : Prdata;
                     state_reg <= S_IDLE;
                  end else begin
                     // Registered slave: its data appears one cycle after completion.
                     state_reg <= S_RCAP;
                  end
               end else if (tmo_hit) begin
                  Psel      <= 1'b0;
                  Penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  state_reg <= S_IDLE;
               end
            end
            S_RCAP: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= Prdata;
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] tmo_cnt_reg;
   logic       rsp_err_reg;

   // The counter holds the number of low-Pready ACCESS cycles already seen;
   // the abort fires on the cycle that would bring it to TIMEOUT.
   assign tmo_hit = (tmo_cnt_reg == TMO_LAST);
   assign rsp_err = rsp_err_reg;

   always_ff @(posedge PCLK or negedge Presetn) begin
      if (!Presetn) begin
         tmo_cnt_reg <= '0;
         rsp_err_reg <= 1'b0;
      end else begin
         if (state_reg == S_SETUP) begin
            tmo_cnt_reg <= '0;
         end else if (state_reg == S_ACCESS && !Pready) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
         end
         // Error flag changes only together with a response so it holds in between.
         if (state_reg == S_ACCESS && !Pready && tmo_hit) begin
            rsp_err_reg <= 1'b1;
         end else if ((state_reg == S_ACCESS && Pready && (Pwrite || RDATA_DLY == 0)) ||
                      state_reg == S_RCAP) begin
            rsp_err_reg <= 1'b0;
         end
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

   localparam int TMO = 4;

   logic        PCLK;
   logic        Presetn;

   // Index 0: bridge with registered-slave timing (RDATA_DLY=1)
   // Index 1: bridge with combinational-slave timing (RDATA_DLY=0)
   logic        cmd_valid [2];
   logic        cmd_ready [2];
   logic        cmd_write [2];
   logic [3:0]  cmd_addr  [2];
   logic [31:0] cmd_wdata [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        busy      [2];
   logic [3:0]  paddr     [2];
   logic        psel      [2];
   logic        penable   [2];
   logic        pwrite    [2];
   logic [31:0] pwdata    [2];
   logic        pready    [2];
   logic [31:0] prdata    [2];

   int checks   = 0;
   int failures = 0;

   apb_master_bridge #(.ADDR_W(4), .DATA_W(32), .RDATA_DLY(1), .TIMEOUT(TMO)) u_dut_reg (
      .PCLK(PCLK), .Presetn(Presetn),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
      .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]),
      .Paddr(paddr[0]), .Psel(psel[0]), .Penable(penable[0]), .Pwrite(pwrite[0]),
      .Pwdata(pwdata[0]), .Pready(pready[0]), .Prdata(prdata[0])
   );

   apb_master_bridge #(.ADDR_W(4), .DATA_W(32), .RDATA_DLY(0), .TIMEOUT(TMO)) u_dut_comb (
      .PCLK(PCLK), .Presetn(Presetn),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
      .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]),
      .Paddr(paddr[1]), .Psel(psel[1]), .Penable(penable[1]), .Pwrite(pwrite[1]),
      .Pwdata(pwdata[1]), .Pready(pready[1]), .Prdata(prdata[1])
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // ---------------- slave models (environment) ----------------
   logic [31:0] smem [2][16];
   int          acc_cnt [2];
   int          wait_n  [2];
   bit          stuck   [2];
   bit          force_hi[2];
   bit          mem_clr;
   logic [31:0] prdata_reg0;

   assign pready[0] = force_hi[0] | (!stuck[0] & psel[0] & penable[0] & (acc_cnt[0] >= wait_n[0]));
   assign pready[1] = force_hi[1] | (!stuck[1] & psel[1] & penable[1] & (acc_cnt[1] >= wait_n[1]));
   assign prdata[0] = prdata_reg0;
   assign prdata[1] = smem[1][paddr[1]];

   always @(posedge PCLK) begin
      for (int k = 0; k < 2; k++) begin
         if (!Presetn) acc_cnt[k] <= 0;
         else if (psel[k] && penable[k] && !pready[k]) acc_cnt[k] <= acc_cnt[k] + 1;
         else acc_cnt[k] <= 0;
         if (mem_clr) begin
            for (int j = 0; j < 16; j++) smem[k][j] <= 32'h0;
         end else if (psel[k] && penable[k] && pready[k]) begin
            if (pwrite[k]) smem[k][paddr[k]] <= pwdata[k];
            else if (k == 0) prdata_reg0 <= smem[0][paddr[0]];
         end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] model   [2][16];
   logic [31:0] last_wd [2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   // ---------------- APB protocol monitor ----------------
   int          mlen  [2];
   logic [3:0]  maddr [2];
   logic        mwr   [2];
   logic [31:0] mwd   [2];

   always @(negedge PCLK) begin
      for (int k = 0; k < 2; k++) begin
         if (!Presetn) begin
            mlen[k] = 0;
         end else if (psel[k]) begin
            if (mlen[k] == 0) begin
               maddr[k] = paddr[k];
               mwr[k]   = pwrite[k];
               mwd[k]   = pwdata[k];
               chk("setup_penable_low", 64'(penable[k]), 64'd0);
            end else begin
               chk("access_penable_high", 64'(penable[k]), 64'd1);
               chk("apb_fields_stable", 64'({paddr[k], pwrite[k], pwdata[k]}),
                   64'({maddr[k], mwr[k], mwd[k]}));
            end
            mlen[k]++;
         end else begin
            if (mlen[k] != 0)
               chk("psel_window_len", 64'(mlen[k]), 64'(stuck[k] ? 1 + TMO : 2 + wait_n[k]));
            mlen[k] = 0;
         end
      end
   end

   // ---------------- transaction task ----------------
   task automatic do_cmd(input int k, input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input int waits, input int exp_lat, input logic [31:0] exp_rd,
                         input bit exp_err);
      int lat;
      wait_n[k] = waits;
      @(negedge PCLK);
      chk("cmd_ready_idle", 64'(cmd_ready[k]), 64'd1);
      cmd_valid[k] = 1'b1;
      cmd_write[k] = wr;
      cmd_addr[k]  = a;
      cmd_wdata[k] = d;
      @(negedge PCLK);
      cmd_valid[k] = 1'b0;
      lat = 1;
      chk("busy_setup", 64'(busy[k]), 64'd1);
      chk("setup_fields", 64'({paddr[k], pwrite[k], pwdata[k]}),
          64'({a, wr, (wr ? d : last_wd[k])}));
      if (wr) last_wd[k] = d;
      while (!rsp_valid[k] && lat < 64) begin
         @(negedge PCLK);
         lat++;
      end
      chk("rsp_latency", 64'(lat), 64'(exp_lat));
      chk("rsp_rdata", 64'(rsp_rdata[k]), 64'(exp_rd));
      chk("rsp_err", 64'(rsp_err[k]), 64'(exp_err));
      $display("txn dut=%0d %s addr=%h wdata=%h waits=%0d lat=%0d rdata=%h err=%b",
               k, wr ? "WR" : "RD", a, d, waits, lat, rsp_rdata[k], rsp_err[k]);
      if (wr && !exp_err) model[k][a] = d;
      @(negedge PCLK);
      chk("rsp_single_pulse", 64'(rsp_valid[k]), 64'd0);
   endtask

   task automatic chk_reset_state(input int k);
      chk("rst_ctl", 64'({psel[k], penable[k], pwrite[k], paddr[k], rsp_valid[k], rsp_err[k],
                          busy[k], cmd_ready[k]}), 64'd1);
      chk("rst_pwdata", 64'(pwdata[k]), 64'd0);
      chk("rst_rdata", 64'(rsp_rdata[k]), 64'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int          k;
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
      int          waits;
      int          exp_lat;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vtab [7];

   initial begin
      int          i, last, cyc, t;
      int          rk, rw;
      bit          rwr;
      logic [3:0]  ra;
      logic [31:0] rd;

      vtab[0] = '{0, 1'b1, 4'h3, 32'hDEADBEEF, 0, 3, 32'h0};
      vtab[1] = '{0, 1'b0, 4'h3, 32'h0,        0, 4, 32'hDEADBEEF};
      vtab[2] = '{1, 1'b1, 4'h7, 32'hA5A5A5A5, 0, 3, 32'h0};
      vtab[3] = '{1, 1'b0, 4'h7, 32'h0,        3, 6, 32'hA5A5A5A5};
      vtab[4] = '{0, 1'b1, 4'h9, 32'h12345678, 2, 5, 32'h0};
      vtab[5] = '{0, 1'b0, 4'h9, 32'h0,        1, 5, 32'h12345678};
      vtab[6] = '{1, 1'b0, 4'h3, 32'h0,        0, 3, 32'h0};

      Presetn = 1'b0;
      mem_clr = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0; cmd_addr[k] = 4'h0; cmd_wdata[k] = 32'h0;
         wait_n[k] = 0; stuck[k] = 1'b0; force_hi[k] = 1'b0; last_wd[k] = 32'h0;
         for (int j = 0; j < 16; j++) model[k][j] = 32'h0;
      end

      // Reset values
      repeat (3) @(negedge PCLK);
      for (int k = 0; k < 2; k++) chk_reset_state(k);
      Presetn = 1'b1;
      mem_clr = 1'b0;
      @(negedge PCLK);
      for (int k = 0; k < 2; k++) chk_reset_state(k);

      // Stray Pready while idle must not start or finish anything
      force_hi[0] = 1'b1;
      force_hi[1] = 1'b1;
      repeat (3) begin
         @(negedge PCLK);
         for (int k = 0; k < 2; k++)
            chk("stray_pready_idle", 64'({rsp_valid[k], busy[k], psel[k]}), 64'd0);
      end
      force_hi[0] = 1'b0;
      force_hi[1] = 1'b0;

      // Directed vectors
      for (int v = 0; v < 7; v++)
         do_cmd(vtab[v].k, vtab[v].wr, vtab[v].addr, vtab[v].data, vtab[v].waits,
                vtab[v].exp_lat, vtab[v].exp_rdata, 1'b0);

      // Back-to-back writes with cmd_valid held high
      wait_n[0] = 0;
      i = 0; last = -1; cyc = 0;
      @(negedge PCLK);
      cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1;
      cmd_addr[0] = 4'h0; cmd_wdata[0] = 32'h1000_0000;
      while (i < 16 && cyc < 200) begin
         if (cmd_ready[0]) begin
            if (last >= 0) chk("b2b_accept_gap", 64'(cyc - last), 64'd3);
            last = cyc;
            model[0][i] = 32'h1000_0000 + 32'(i);
            i++;
            @(negedge PCLK); cyc++;
            if (i < 16) begin
               cmd_addr[0]  = 4'(i);
               cmd_wdata[0] = 32'h1000_0000 + 32'(i);
            end else begin
               cmd_valid[0] = 1'b0;
            end
         end else begin
            @(negedge PCLK); cyc++;
         end
      end
      cmd_valid[0] = 1'b0;
      chk("b2b_accept_count", 64'(i), 64'd16);
      last_wd[0] = 32'h1000_000F;
      t = 0;
      while (busy[0] && t < 20) begin @(negedge PCLK); t++; end
      chk("b2b_drain", 64'(busy[0]), 64'd0);
      for (int j = 0; j < 16; j++)
         do_cmd(0, 1'b0, 4'(j), 32'h0, 0, 4, model[0][j], 1'b0);

      // Randomized traffic against the model
      for (int r = 0; r < 60; r++) begin
         rk  = int'($urandom_range(0, 1));
         rwr = 1'($urandom_range(0, 1));
         ra  = 4'($urandom_range(0, 15));
         rd  = $urandom;
         rw  = int'($urandom_range(0, 2));
         do_cmd(rk, rwr, ra, rd, rw, 3 + rw + ((!rwr && rk == 0) ? 1 : 0),
                rwr ? 32'h0 : model[rk][ra], 1'b0);
      end

`ifdef APB_MASTER_TIMEOUT_EN
      // Pready stuck low: abort after TMO ACCESS cycles, then recover
      stuck[0] = 1'b1;
      do_cmd(0, 1'b0, 4'h5, 32'h0, 0, 2 + TMO, 32'h0, 1'b1);
      stuck[0] = 1'b0;
      do_cmd(0, 1'b0, 4'h5, 32'h0, 0, 4, model[0][5], 1'b0);
      // Ready arriving on the last allowed cycle completes normally
      do_cmd(1, 1'b1, 4'h6, 32'h600D0006, TMO - 1, 3 + TMO - 1, 32'h0, 1'b0);
      do_cmd(1, 1'b0, 4'h6, 32'h0, TMO - 1, 3 + TMO - 1, 32'h600D0006, 1'b0);
`endif

      // Asynchronous reset in the middle of a write ACCESS
      wait_n[0] = 5;
      @(negedge PCLK);
      cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 4'hC; cmd_wdata[0] = 32'hCAFE0001;
      @(negedge PCLK);
      cmd_valid[0] = 1'b0;
      @(negedge PCLK);
      chk("mr_in_access", 64'({psel[0], penable[0]}), 64'd3);
      @(posedge PCLK);
      #2 Presetn = 1'b0;
      #1 chk("mr_async_clear", 64'({psel[0], penable[0], rsp_valid[0], busy[0], paddr[0], cmd_ready[0]}),
             64'd1);
      @(negedge PCLK);
      #2 Presetn = 1'b1;
      wait_n[0] = 0;
      last_wd[0] = 32'h0;
      last_wd[1] = 32'h0;
      repeat (8) begin
         @(negedge PCLK);
         chk("mr_no_response", 64'({rsp_valid[0], psel[0], busy[0]}), 64'd0);
      end
      do_cmd(0, 1'b0, 4'hC, 32'h0, 0, 4, model[0][12], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation did not finish");
   end

endmodule
